// File: rtl/universal_ff_bank_if.sv
// Bundle of control, data and status signals for universal_ff_bank.
// The master drives the controls and data inputs; the slave (the flip-flop bank) returns
// the state and status.
interface universal_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic [1:0]       mode;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             sr_err;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, mode, clr, load, load_data, a, b, err_clr,
    input  q, q_n, sr_err, chg_cnt
  );

  modport slave (
    input  en, mode, clr, load, load_data, a, b, err_clr,
    output q, q_n, sr_err, chg_cnt
  );
endinterface

// File: rtl/universal_ff_bank.sv
// universal_ff_bank: WIDTH-bit flip-flop bank with one shared run-time mode (D, T, JK, SR).
// It also provides a parallel load, a synchronous clear, a sticky SR-invalid flag and a
// saturating count of the cycles in which q changed.
module universal_ff_bank #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned        SR11_MODE = 32'd0,
  parameter int                 CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  universal_ff_bank_if.slave  bus
);

  localparam logic [1:0]       MODE_D  = 2'b00;
  localparam logic [1:0]       MODE_T  = 2'b01;
  localparam logic [1:0]       MODE_JK = 2'b10;
  localparam logic [1:0]       MODE_SR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             err_r;
  logic             err_next_s;
  logic             sr_hit_s;

  // Resolves S=R=1 on one channel: force 0, force 1, or hold (modes 0 and 3).
  function automatic logic sr11_bit(input logic cur);
    if (SR11_MODE == 32'd1) begin
      return 1'b0;
    end else if (SR11_MODE == 32'd2) begin
      return 1'b1;
    end else begin
      return cur;
    end
  endfunction

  // Per-channel next state when the bank is enabled under the current mode.
  always_comb begin
    step_s = q_r;
    for (int i = 0; i < WIDTH; i++) begin
      case (bus.mode)
        MODE_D:  step_s[i] = bus.a[i];
        MODE_T:  step_s[i] = q_r[i] ^ bus.a[i];
        MODE_JK: begin
          case ({bus.a[i], bus.b[i]})
            2'b01:   step_s[i] = 1'b0;
            2'b10:   step_s[i] = 1'b1;
            2'b11:   step_s[i] = ~q_r[i];
            default: step_s[i] = q_r[i];
          endcase
        end
        MODE_SR: begin
          case ({bus.a[i], bus.b[i]})
            2'b01:   step_s[i] = 1'b0;
            2'b10:   step_s[i] = 1'b1;
            2'b11:   step_s[i] = sr11_bit(q_r[i]);
            default: step_s[i] = q_r[i];
          endcase
        end
        default: step_s[i] = q_r[i];
      endcase
    end
  end

  // An invalid S=R=1 only counts when the SR step would actually be taken.
  assign sr_hit_s = bus.en && !bus.clr && !bus.load && (bus.mode == MODE_SR) &&
                    (|(bus.a & bus.b));

  // Priority clr > load > en > hold, plus the counter and error-flag next values.
  always_comb begin
    next_s     = q_r;
    cnt_next_s = cnt_r;
    err_next_s = err_r;
    if (bus.clr) begin
      next_s = RESET_VAL;
    end else if (bus.load) begin
      next_s = bus.load_data;
    end else if (bus.en) begin
      next_s = step_s;
    end else begin
      next_s = q_r;
    end

    if (bus.clr) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if ((next_s != q_r) && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_r;
    end

    if (sr_hit_s) begin
      err_next_s = 1'b1;
    end else if (bus.err_clr) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err_r;
    end
  end

  // State, counter and sticky error registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= RESET_VAL;
      cnt_r <= {CNT_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      q_r   <= next_s;
      cnt_r <= cnt_next_s;
      err_r <= err_next_s;
    end
  end

  assign bus.q       = q_r;
  assign bus.q_n     = ~q_r;
  assign bus.sr_err  = err_r;
  assign bus.chg_cnt = cnt_r;

endmodule
